// File: rtl/vga_text_ctrl.sv
// Text-mode terminal controller: turns an ASCII byte stream into char RAM
// writes, tracks the cursor, scrolls/clears by copying in RAM, blinks cursor.
module vga_text_ctrl #(
  parameter int unsigned COLS      = 70,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [6:0]  h_cur,
  output logic [4:0]  v_cur,
  output logic        cursor_blink,
  output logic        busy
);

  localparam int unsigned BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0]  LAST_DST = 5'(ROWS - 2);
  localparam logic [7:0]  SPACE    = 8'h20;

  typedef enum logic [2:0] {
    CLEAR, IDLE, EXEC, SCROLL_RD, SCROLL_WR, SCROLL_CLR
  } state_t;

  state_t         state;
  state_t         exec_next;
  logic [4:0]     row_ptr;
  logic [6:0]     col_ptr;
  logic [BW-1:0]  blink_cnt;
  logic           is_print_c;
  logic           newline_c;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  assign is_print_c = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign newline_c  = (in_char == 8'h0A) || (is_print_c && (h_cur == LAST_COL));

  // Byte decode happens on the accept edge so the write and cursor move are
  // visible during EXEC; EXEC then dispatches to the follow-up state.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      exec_next <= IDLE;
      row_ptr   <= '0;
      col_ptr   <= '0;
      h_cur     <= '0;
      v_cur     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= {row_ptr, col_ptr};
          wr_data <= SPACE;
          if (col_ptr == LAST_COL) begin
            col_ptr <= '0;
            if (row_ptr == LAST_ROW) begin
              row_ptr <= '0;
              state   <= IDLE;
            end else begin
              row_ptr <= row_ptr + 5'd1;
            end
          end else begin
            col_ptr <= col_ptr + 7'd1;
          end
        end

        IDLE: begin
          if (in_valid) begin
            state     <= EXEC;
            exec_next <= IDLE;
            if (is_print_c) begin
              wr_en   <= 1'b1;
              wr_addr <= {v_cur, h_cur};
              wr_data <= in_char;
              h_cur   <= (h_cur == LAST_COL) ? 7'd0 : h_cur + 7'd1;
            end else begin
              case (in_char)
                8'h0A, 8'h0D: h_cur <= '0;
                8'h08: begin
                  if (h_cur != 7'd0) begin
                    h_cur   <= h_cur - 7'd1;
                    wr_en   <= 1'b1;
                    wr_addr <= {v_cur, h_cur - 7'd1};
                    wr_data <= SPACE;
                  end else if (v_cur != 5'd0) begin
                    h_cur   <= LAST_COL;
                    v_cur   <= v_cur - 5'd1;
                    wr_en   <= 1'b1;
                    wr_addr <= {v_cur - 5'd1, LAST_COL};
                    wr_data <= SPACE;
                  end
                end
                8'h0C: begin
                  h_cur     <= '0;
                  v_cur     <= '0;
                  exec_next <= CLEAR;
                end
                default: ;
              endcase
            end
            if (newline_c) begin
              if (v_cur != LAST_ROW) v_cur <= v_cur + 5'd1;
              else exec_next <= SCROLL_RD;
            end
          end
        end

        EXEC: begin
          state   <= exec_next;
          row_ptr <= '0;
          col_ptr <= '0;
          rd_addr <= {5'd1, 7'd0};
        end

        SCROLL_RD: state <= SCROLL_WR;

        // rd_data belongs to the address presented during SCROLL_RD
        SCROLL_WR: begin
          wr_en   <= 1'b1;
          wr_addr <= {row_ptr, col_ptr};
          wr_data <= rd_data;
          state   <= SCROLL_RD;
          if (col_ptr == LAST_COL) begin
            col_ptr <= '0;
            if (row_ptr == LAST_DST) begin
              state <= SCROLL_CLR;
            end else begin
              row_ptr <= row_ptr + 5'd1;
              rd_addr <= {row_ptr + 5'd2, 7'd0};
            end
          end else begin
            col_ptr <= col_ptr + 7'd1;
            rd_addr <= {row_ptr + 5'd1, col_ptr + 7'd1};
          end
        end

        SCROLL_CLR: begin
          wr_en   <= 1'b1;
          wr_addr <= {LAST_ROW, col_ptr};
          wr_data <= SPACE;
          if (col_ptr == LAST_COL) begin
            col_ptr <= '0;
            state   <= IDLE;
          end else begin
            col_ptr <= col_ptr + 7'd1;
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

  // Free-running blink phase divider
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      blink_cnt    <= '0;
      cursor_blink <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt    <= '0;
      cursor_blink <= ~cursor_blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Terminal controller that sequences writes into the text-mode character RAM scanned by the VGA character renderer. It accepts ASCII bytes over a valid/ready stream and maintains the cursor position (h_cur/v_cur) fed to the renderer. It interprets control codes and performs hardware scroll and clear by copying within the char RAM. It also generates the cursor blink strobe.

Parameters:
COLS, 70, visible text columns (≤128)
ROWS, 30, visible text rows (≤32)
BLINK_DIV, 25000000, pclk cycles per cursor_blink toggle

Ports:
pclk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  input byte valid
in_char  in  8  ASCII byte
in_ready  out  1  controller can accept a byte (high only in IDLE)
wr_en  out  1  char RAM write strobe, one cycle per write
wr_addr  out  12  char RAM address {row[4:0], col[6:0]}
wr_data  out  8  char RAM write data
rd_addr  out  12  char RAM read address {row, col}; RAM returns rd_data one cycle later
rd_data  in  8  char RAM read data
h_cur  out  7  cursor column
v_cur  out  5  cursor row
cursor_blink  out  1  blink phase to renderer
busy  out  1  high in any state other than IDLE

Behaviour:
- States: CLEAR, IDLE, EXEC, SCROLL_RD, SCROLL_WR, SCROLL_CLR. in_ready = (state==IDLE); busy = ~in_ready.
- Reset (rst=0, async): state=CLEAR, clear pointer=0, h_cur=0, v_cur=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, cursor_blink=0, blink counter=0.
- CLEAR: one write per cycle of 0x20 to every {r,c}, r<ROWS, c<COLS, row-major. Exactly ROWS*COLS cycles with wr_en=1 (2100 at defaults), then IDLE. Columns ≥COLS are never written.
- Accept: in_valid&in_ready at edge N latches in_char and moves to EXEC. Cycle N+1 (EXEC) drives any wr_en and updates the cursor. Next state is IDLE, SCROLL_RD or CLEAR. Max throughput is 1 byte per 2 cycles.
- EXEC by byte:
  - 0x20..0x7E: write byte at {v_cur,h_cur}. If h_cur<COLS-1, h_cur+1; otherwise h_cur=0 and newline.
  - 0x0A (LF): h_cur=0, newline.
  - 0x0D (CR): h_cur=0.
  - 0x08 (BS): if h_cur>0, h_cur-1 and write 0x20 at the new position. Else if v_cur>0, v_cur-1, h_cur=COLS-1, write 0x20 there. Else no write and no move.
  - 0x0C (FF): h_cur=0, v_cur=0, go to CLEAR.
  - Any other byte: consumed, no write, no move.
- Newline: if v_cur<ROWS-1, v_cur+1 and go to IDLE. If v_cur==ROWS-1, v_cur stays and the controller goes to SCROLL_RD.
- Scroll, for each dst row d=0..ROWS-2 and col c=0..COLS-1:
  - SCROLL_RD: rd_addr={d+1,c}, wr_en=0.
  - SCROLL_WR: wr_addr={d,c}, wr_data=rd_data, wr_en=1.
  - After the last copy, SCROLL_CLR writes 0x20 to {ROWS-1,c} for every c, one per cycle.
  - Total busy cycles after EXEC: 2*COLS*(ROWS-1)+COLS = 4130 at defaults. Then IDLE.
- Cursor outputs are stable during scroll and clear; they hold their EXEC values.
- cursor_blink toggles each time the counter reaches BLINK_DIV-1; counter then returns to 0. It free-runs in all states.
- wr_en is registered and high only in the cycles stated above. wr_addr/wr_data are don't-care when wr_en=0 but must not glitch X.
- Reset asserted mid-scroll or mid-clear aborts immediately. After release, a full CLEAR is performed and the cursor is at 0,0.
- in_valid held while busy: the byte is not consumed and must be accepted on the first IDLE cycle.

Test Plan:
- Release reset -> exactly 2100 wr_en pulses, all data 0x20, addresses {0..29,0..69}; then in_ready=1, h_cur=0, v_cur=0.
- Send 'A' (0x41) at h_cur=69,v_cur=3 -> write {3,69}=0x41 in the cycle after accept; then h_cur=0, v_cur=4, in_ready back to 1 one cycle later.
- Preload row 29 with 'Z', send LF at v_cur=29 -> rows 0..28 hold old rows 1..29, row 29 = 0x20; busy for 4130 cycles after EXEC; v_cur=29, h_cur=0.
- BS at h_cur=0,v_cur=5 -> write 0x20 at {4,69}, h_cur=69, v_cur=4. BS at 0,0 -> no wr_en, cursor unchanged.
- Hold in_valid with 'B' during a scroll -> in_ready=0 throughout and the byte is not lost; accepted on the first IDLE cycle and written at {29,0}.
- Send 0x0C, then assert rst low midway through the clear -> outputs return to reset values immediately; after release, a full 2100-write clear completes.
